// File: rtl/mem_responder_pkg.sv
// Types shared between the RV32I control FSM and the memory responder.
// Lane-mask constants for sw/sh/sb and the latched operation kind.
package rv32i_types;

  typedef enum logic [3:0] {
    BE_SB = 4'b0001,
    BE_SH = 4'b0011,
    BE_SW = 4'b1111
  } mem_byte_enable_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/mem_responder_if.sv
// Core memory-port handshake bundle: the core is the master, the
// responder is the slave.
interface mem_responder_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        err;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp, err
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp, err
  );
endinterface

// File: rtl/mem_responder_array.sv
// Single-port word array with per-byte write enables and a registered,
// read-enabled output that holds its value between reads.
module mem_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 re,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [0:(1<<ADDR_BITS)-1];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= 32'h0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory target for the multicycle core: accepts one held request, waits
// LATENCY cycles, then pulses mem_resp for one cycle.
//
//   state | meaning
//   IDLE  | waiting for exactly one of mem_read/mem_write
//   BUSY  | latency countdown; dropped request aborts
//   RESP  | mem_resp pulse; write commits at closing edge
module mem_responder
  import rv32i_types::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  state_t                 state, state_n;
  logic [CW-1:0]          count, count_n;
  logic [ADDR_BITS-1:0]   idx_q;
  mem_op_t                op_q;
  logic [3:0]             be_q;
  logic [31:0]            wdata_q;
  logic                   err_q;
  logic                   resp_q;

  logic                   accept;
  logic                   set_err;
  logic                   req_held;
  logic                   rd_en;
  logic                   wr_en;
  logic [ADDR_BITS-1:0]   arr_addr;
  logic                   unused_addr;

  assign unused_addr = ^{bus.mem_address[31:ADDR_BITS+2], bus.mem_address[1:0]};
  assign req_held    = (op_q == OP_READ) ? bus.mem_read : bus.mem_write;

  always_comb begin
    state_n  = state;
    count_n  = count;
    accept   = 1'b0;
    set_err  = 1'b0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    arr_addr = idx_q;
    case (state)
      IDLE: begin
        // The array read must launch at the accepting edge when LATENCY is 1,
        // so the live address is used here rather than the latch.
        arr_addr = bus.mem_address[ADDR_BITS+1:2];
        if (bus.mem_read && bus.mem_write) begin
          set_err = 1'b1;
        end else if (bus.mem_read ^ bus.mem_write) begin
          accept  = 1'b1;
          count_n = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_n = RESP;
            rd_en   = bus.mem_read;
          end else begin
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req_held) begin
          state_n = IDLE;
          count_n = '0;
        end else begin
          count_n = count - CW'(1);
          if (count == CW'(1)) begin
            state_n = RESP;
            rd_en   = (op_q == OP_READ);
          end
        end
      end
      RESP: begin
        state_n = IDLE;
        wr_en   = (op_q == OP_WRITE);
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      err_q  <= 1'b0;
      resp_q <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      resp_q <= (state_n == RESP);
      if (set_err) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      op_q    <= OP_READ;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      idx_q   <= bus.mem_address[ADDR_BITS+1:2];
      op_q    <= bus.mem_write ? OP_WRITE : OP_READ;
      be_q    <= bus.mem_byte_enable;
      wdata_q <= bus.mem_wdata;
    end
  end

  mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .rst   (rst),
    .addr  (arr_addr),
    .re    (rd_en),
    .we    (wr_en),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (bus.mem_rdata)
  );

  assign bus.mem_resp = resp_q;
  assign bus.err      = err_q;

endmodule
